decode_id: RTL and testbench
============================

Name: decode_id

Overview:
- Instruction-decode stage of the 5-stage MIPS-subset pipeline. Sits directly downstream of the fetch stage and consumes its IF/ID outputs (instruction, PC+4).
- Contains:
  - the 32x32 register file, written from the WB stage;
  - the main control decoder;
  - the 16-to-32 sign extender;
  - the ID/EX pipeline latch that feeds the execute stage.

Parameters:
- NUM_REGS, 32, number of architectural registers (index width = 5).
- DATA_W, 32, register and datapath width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- if_id_instr  input  32  instruction from the IF/ID latch.
- if_id_npc  input  32  PC+4 from the IF/ID latch.
- wb_reg_write  input  1  write-back enable from MEM/WB.
- wb_write_reg  input  5  write-back destination register.
- wb_write_data  input  32  write-back data.
- flush  input  1  synchronous bubble insert (driven by ex_mem_pc_src on a taken branch).
- id_ex_wb  output  2  {RegWrite, MemToReg}.
- id_ex_m  output  3  {Branch, MemRead, MemWrite}.
- id_ex_ex  output  4  {RegDst, ALUOp[1:0], ALUSrc}.
- id_ex_npc  output  32  latched PC+4.
- id_ex_rdata1  output  32  latched value of register rs (instr[25:21]).
- id_ex_rdata2  output  32  latched value of register rt (instr[20:16]).
- id_ex_sign_ext  output  32  latched sign-extended instr[15:0].
- id_ex_rt  output  5  latched instr[20:16].
- id_ex_rd  output  5  latched instr[15:11].

Behaviour:
- Reset (async, rst=1):
  - all ID/EX outputs are 0;
  - all register-file entries are 0;
  - takes effect immediately, mid-operation included.
  - First capture happens on the first rising clk after rst deasserts.
- Latency: outputs reflect if_id_instr/if_id_npc one clk edge after they are presented. The ID/EX latch loads every cycle; there is no stall input.
- Register file:
  - Write on rising clk when wb_reg_write=1 and wb_write_reg!=0.
  - Writes to $0 are ignored; reads of $0 always return 0.
  - Read ports are combinational.
  - Write-through bypass: if wb_reg_write=1, wb_write_reg!=0 and wb_write_reg equals the read index, the read returns wb_write_data in the same cycle. This replaces the write-first-half/read-second-half convention. Applies independently to both read ports.
- Control decode on opcode instr[31:26]:
  - 000000 R-type: wb=10, m=000, ex=1100.
  - 100011 lw: wb=11, m=010, ex=0001.
  - 101011 sw: wb=00, m=001, ex=0001.
  - 000100 beq: wb=00, m=100, ex=0010.
  - Any other opcode: all control bits 0 (nop); data fields still latched.
- Sign extension: {{16{instr[15]}}, instr[15:0]}.
- flush=1 at a clock edge:
  - id_ex_wb, id_ex_m and id_ex_ex load 0 (bubble);
  - data fields (npc, rdata, sign_ext, rt, rd) load normally;
  - the register-file write in the same cycle still occurs.
- Instruction 0x00000000 (sll $0) decodes as R-type targeting $0; it is architecturally harmless.

Decomposition:
- Shared package (pipeline_pkg) holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ;
  - bit-index constants for the wb/m/ex control bundles, reused by the EX/MEM/WB stages;
  - the REG_IDX_W=5 constant.
- One natural sub-module: reg_file. It contains the 2-read/1-write array, $0 hardwiring, bypass logic and async clear.
- Control decode and the ID/EX latch stay in decode_id.

Test Plan:
- Assert rst mid-run after several writes → all outputs 0 immediately; after release, reading $8 returns 0.
- WB writes $8=0x000000AA, then present add $10,$8,$9 (0x01095020) → next edge: rdata1=0xAA, wb=10, m=000, ex=1100, rd=10, rt=9.
- Present lw $9,-4($8) (0x8D09FFFC) → sign_ext=0xFFFFFFFC, wb=11, m=010, ex=0001, rt=9.
- Present an instruction reading $8 in the same cycle that WB writes $8=0x00001234 → rdata1=0x00001234 (bypass). Also WB writes $0=0xDEAD → reading $0 returns 0.
- Present beq $1,$2,3 (0x10220003) → m=100, ex=0010, wb=00, sign_ext=3. Repeat with flush=1 → all controls 0, npc still latched.
- Present j opcode 0x08000000 → all controls 0, sign_ext=0, id_ex_npc=if_id_npc.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcodes, control-bundle bit positions
// and register index width used by the ID, EX, MEM and WB stages.
package pipeline_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  // wb = {RegWrite, MemToReg}
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  // m = {Branch, MemRead, MemWrite}
  localparam int M_BRANCH    = 2;
  localparam int M_MEM_READ  = 1;
  localparam int M_MEM_WRITE = 0;

  // ex = {RegDst, ALUOp[1:0], ALUSrc}
  localparam int EX_REG_DST   = 3;
  localparam int EX_ALU_OP_HI = 2;
  localparam int EX_ALU_OP_LO = 1;
  localparam int EX_ALU_SRC   = 0;

endpackage

// File: rtl/reg_file.sv
// 2-read/1-write register file with $0 hardwired to zero and
// write-through bypass so WB data is visible to ID in the same cycle.
module reg_file
  import pipeline_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_we,
  input  logic [REG_IDX_W-1:0] i_waddr,
  input  logic [DATA_W-1:0]    i_wdata,
  input  logic [REG_IDX_W-1:0] i_raddr1,
  input  logic [REG_IDX_W-1:0] i_raddr2,
  output logic [DATA_W-1:0]    o_rdata1,
  output logic [DATA_W-1:0]    o_rdata2
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_wr;

  assign w_wr = i_we && (i_waddr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata1 = r_regs[i_raddr1];
    if (i_raddr1 == '0)
      o_rdata1 = '0;
    else if (w_wr && (i_waddr == i_raddr1))
      o_rdata1 = i_wdata;
  end

  always_comb begin
    o_rdata2 = r_regs[i_raddr2];
    if (i_raddr2 == '0)
      o_rdata2 = '0;
    else if (w_wr && (i_waddr == i_raddr2))
      o_rdata2 = i_wdata;
  end

endmodule

// File: rtl/decode_id.sv
// ID stage: register read, main control decode, sign extension
// and the ID/EX pipeline latch.
module decode_id
  import pipeline_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          if_id_instr,
  input  logic [31:0]          if_id_npc,
  input  logic                 wb_reg_write,
  input  logic [REG_IDX_W-1:0] wb_write_reg,
  input  logic [DATA_W-1:0]    wb_write_data,
  input  logic                 flush,
  output logic [WB_W-1:0]      id_ex_wb,
  output logic [M_W-1:0]       id_ex_m,
  output logic [EX_W-1:0]      id_ex_ex,
  output logic [31:0]          id_ex_npc,
  output logic [DATA_W-1:0]    id_ex_rdata1,
  output logic [DATA_W-1:0]    id_ex_rdata2,
  output logic [DATA_W-1:0]    id_ex_sign_ext,
  output logic [REG_IDX_W-1:0] id_ex_rt,
  output logic [REG_IDX_W-1:0] id_ex_rd
);

  logic [5:0]           w_opcode;
  logic [REG_IDX_W-1:0] w_rs;
  logic [REG_IDX_W-1:0] w_rt;
  logic [REG_IDX_W-1:0] w_rd;
  logic [DATA_W-1:0]    w_rdata1;
  logic [DATA_W-1:0]    w_rdata2;
  logic [DATA_W-1:0]    w_sext;
  logic [WB_W-1:0]      w_wb;
  logic [M_W-1:0]       w_m;
  logic [EX_W-1:0]      w_ex;

  assign w_opcode = if_id_instr[31:26];
  assign w_rs     = if_id_instr[25:21];
  assign w_rt     = if_id_instr[20:16];
  assign w_rd     = if_id_instr[15:11];
  assign w_sext   = {{(DATA_W-16){if_id_instr[15]}},
                     if_id_instr[15:0]};

  reg_file #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .i_we     (wb_reg_write),
    .i_waddr  (wb_write_reg),
    .i_wdata  (wb_write_data),
    .i_raddr1 (w_rs),
    .i_raddr2 (w_rt),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2)
  );

  always_comb begin
    w_wb = '0;
    w_m  = '0;
    w_ex = '0;
    unique case (w_opcode)
      OP_RTYPE: begin
        w_wb[WB_REG_WRITE] = 1'b1;
        w_ex[EX_REG_DST]   = 1'b1;
        w_ex[EX_ALU_OP_HI] = 1'b1;
      end
      OP_LW: begin
        w_wb[WB_REG_WRITE]  = 1'b1;
        w_wb[WB_MEM_TO_REG] = 1'b1;
        w_m[M_MEM_READ]     = 1'b1;
        w_ex[EX_ALU_SRC]    = 1'b1;
      end
      OP_SW: begin
        w_m[M_MEM_WRITE] = 1'b1;
        w_ex[EX_ALU_SRC] = 1'b1;
      end
      OP_BEQ: begin
        w_m[M_BRANCH]      = 1'b1;
        w_ex[EX_ALU_OP_LO] = 1'b1;
      end
      default: ;
    endcase
  end

  // flush only bubbles the control bundles; data still flows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_wb       <= '0;
      id_ex_m        <= '0;
      id_ex_ex       <= '0;
      id_ex_npc      <= '0;
      id_ex_rdata1   <= '0;
      id_ex_rdata2   <= '0;
      id_ex_sign_ext <= '0;
      id_ex_rt       <= '0;
      id_ex_rd       <= '0;
    end else begin
      id_ex_wb       <= flush ? '0 : w_wb;
      id_ex_m        <= flush ? '0 : w_m;
      id_ex_ex       <= flush ? '0 : w_ex;
      id_ex_npc      <= if_id_npc;
      id_ex_rdata1   <= w_rdata1;
      id_ex_rdata2   <= w_rdata2;
      id_ex_sign_ext <= w_sext;
      id_ex_rt       <= w_rt;
      id_ex_rd       <= w_rd;
    end
  end

endmodule

// File: tb/tb_decode_id.sv
// Directed-vector bench for decode_id with hand-computed
// expected values.
module tb_decode_id;

  logic        clk;
  logic        rst;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_npc;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        flush;
  logic [1:0]  id_ex_wb;
  logic [2:0]  id_ex_m;
  logic [3:0]  id_ex_ex;
  logic [31:0] id_ex_npc;
  logic [31:0] id_ex_rdata1;
  logic [31:0] id_ex_rdata2;
  logic [31:0] id_ex_sign_ext;
  logic [4:0]  id_ex_rt;
  logic [4:0]  id_ex_rd;

  int n_asserts = 0;
  int n_fails   = 0;

  decode_id dut (
    .clk            (clk),
    .rst            (rst),
    .if_id_instr    (if_id_instr),
    .if_id_npc      (if_id_npc),
    .wb_reg_write   (wb_reg_write),
    .wb_write_reg   (wb_write_reg),
    .wb_write_data  (wb_write_data),
    .flush          (flush),
    .id_ex_wb       (id_ex_wb),
    .id_ex_m        (id_ex_m),
    .id_ex_ex       (id_ex_ex),
    .id_ex_npc      (id_ex_npc),
    .id_ex_rdata1   (id_ex_rdata1),
    .id_ex_rdata2   (id_ex_rdata2),
    .id_ex_sign_ext (id_ex_sign_ext),
    .id_ex_rt       (id_ex_rt),
    .id_ex_rd       (id_ex_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctrl(input string tag,
                          input logic [1:0] wb,
                          input logic [2:0] m,
                          input logic [3:0] ex);
    check({tag, ".wb"}, {30'd0, id_ex_wb}, {30'd0, wb});
    check({tag, ".m"},  {29'd0, id_ex_m},  {29'd0, m});
    check({tag, ".ex"}, {28'd0, id_ex_ex}, {28'd0, ex});
  endtask

  task automatic chk_all_zero(input string tag);
    chk_ctrl(tag, 2'b00, 3'b000, 4'b0000);
    check({tag, ".npc"}, id_ex_npc, 32'h0);
    check({tag, ".rd1"}, id_ex_rdata1, 32'h0);
    check({tag, ".rd2"}, id_ex_rdata2, 32'h0);
    check({tag, ".sext"}, id_ex_sign_ext, 32'h0);
    check({tag, ".rt"}, {27'd0, id_ex_rt}, 32'h0);
    check({tag, ".rdi"}, {27'd0, id_ex_rd}, 32'h0);
  endtask

  task automatic wb_set(input logic we,
                        input logic [4:0] r,
                        input logic [31:0] d);
    wb_reg_write  = we;
    wb_write_reg  = r;
    wb_write_data = d;
  endtask

  initial begin
    rst = 1'b1;
    if_id_instr = 32'h8D09FFFC;
    if_id_npc   = 32'h0000_0100;
    flush = 1'b0;
    wb_set(1'b1, 5'd8, 32'hFFFF_FFFF);
    tick();
    tick();
    chk_all_zero("reset");

    #2 rst = 1'b0;
    wb_set(1'b1, 5'd8, 32'h0000_00AA);
    if_id_instr = 32'h0000_0000;
    if_id_npc   = 32'h0000_0100;
    tick();
    chk_ctrl("sll0", 2'b10, 3'b000, 4'b1100);

    wb_set(1'b0, 5'd0, 32'h0);
    if_id_instr = 32'h01095020;
    if_id_npc   = 32'h0000_0104;
    tick();
    chk_ctrl("add", 2'b10, 3'b000, 4'b1100);
    check("add.rd1", id_ex_rdata1, 32'h0000_00AA);
    check("add.rd2", id_ex_rdata2, 32'h0);
    check("add.rd", {27'd0, id_ex_rd}, 32'd10);
    check("add.rt", {27'd0, id_ex_rt}, 32'd9);
    check("add.npc", id_ex_npc, 32'h0000_0104);
    check("add.sext", id_ex_sign_ext, 32'h0000_5020);

    if_id_instr = 32'h8D09FFFC;
    if_id_npc   = 32'h0000_0108;
    tick();
    chk_ctrl("lw", 2'b11, 3'b010, 4'b0001);
    check("lw.sext", id_ex_sign_ext, 32'hFFFF_FFFC);
    check("lw.rt", {27'd0, id_ex_rt}, 32'd9);
    check("lw.rd1", id_ex_rdata1, 32'h0000_00AA);

    if_id_instr = 32'hAD09_0010;
    if_id_npc   = 32'h0000_010C;
    tick();
    chk_ctrl("sw", 2'b00, 3'b001, 4'b0001);
    check("sw.sext", id_ex_sign_ext, 32'h0000_0010);

    wb_set(1'b1, 5'd8, 32'h0000_1234);
    if_id_instr = 32'h01095020;
    tick();
    check("byp.rd1", id_ex_rdata1, 32'h0000_1234);

    wb_set(1'b1, 5'd9, 32'h0000_0099);
    tick();
    check("byp.rd2", id_ex_rdata2, 32'h0000_0099);
    check("byp.keep", id_ex_rdata1, 32'h0000_1234);

    wb_set(1'b1, 5'd0, 32'h0000_DEAD);
    if_id_instr = 32'h0000_0020;
    tick();
    check("r0.byp1", id_ex_rdata1, 32'h0);
    check("r0.byp2", id_ex_rdata2, 32'h0);

    wb_set(1'b0, 5'd0, 32'h0);
    tick();
    check("r0.rd1", id_ex_rdata1, 32'h0);

    if_id_instr = 32'h10220003;
    if_id_npc   = 32'h0000_0200;
    tick();
    chk_ctrl("beq", 2'b00, 3'b100, 4'b0010);
    check("beq.sext", id_ex_sign_ext, 32'h0000_0003);
    check("beq.rd1", id_ex_rdata1, 32'h0);

    flush = 1'b1;
    if_id_npc = 32'h0000_0204;
    wb_set(1'b1, 5'd1, 32'h0000_0055);
    tick();
    chk_ctrl("flush", 2'b00, 3'b000, 4'b0000);
    check("flush.npc", id_ex_npc, 32'h0000_0204);
    check("flush.sext", id_ex_sign_ext, 32'h0000_0003);
    check("flush.rt", {27'd0, id_ex_rt}, 32'd2);

    flush = 1'b0;
    wb_set(1'b0, 5'd0, 32'h0);
    if_id_npc = 32'h0000_0208;
    tick();
    chk_ctrl("beq2", 2'b00, 3'b100, 4'b0010);
    check("flush.wr", id_ex_rdata1, 32'h0000_0055);

    if_id_instr = 32'h0800_0000;
    if_id_npc   = 32'h0000_0300;
    tick();
    chk_ctrl("j", 2'b00, 3'b000, 4'b0000);
    check("j.sext", id_ex_sign_ext, 32'h0);
    check("j.npc", id_ex_npc, 32'h0000_0300);

    if_id_instr = 32'h3C08_8000;
    tick();
    chk_ctrl("lui", 2'b00, 3'b000, 4'b0000);
    check("lui.sext", id_ex_sign_ext, 32'hFFFF_8000);

    if_id_instr = 32'h8D09FFFC;
    tick();
    check("pre.rd1", id_ex_rdata1, 32'h0000_1234);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    tick();
    #2 rst = 1'b0;
    if_id_instr = 32'h01095020;
    if_id_npc   = 32'h0000_0400;
    tick();
    check("post.rd1", id_ex_rdata1, 32'h0);
    check("post.rd2", id_ex_rdata2, 32'h0);
    check("post.npc", id_ex_npc, 32'h0000_0400);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fails);
    $finish;
  end

endmodule
